csr_encoder: RTL and testbench
==============================

CSR_ENCODER -- requirements
Module: csr_encoder

Interface
REQ-001 Parameters: ROWS default 560, number of matrix rows; COLS default 1120, number of matrix columns; NNZ_AW default 14, nonzero-store address width; ROW_AW default 10, row-pointer address width.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle pulse, begins a new matrix.
REQ-005 in_data  in  32  dense matrix element, row-major order.
REQ-006 in_valid  in  1  in_data is valid.
REQ-007 in_ready  out  1  encoder accepts in_data; transfer occurs when in_valid and in_ready are both high.
REQ-008 sp_we  out  1  write strobe shared by the value store and the column store.
REQ-009 sp_addr  out  NNZ_AW  nonzero index.
REQ-010 sp_data  out  32  nonzero value.
REQ-011 col_data  out  32  column index of the nonzero, zero-extended.
REQ-012 row_we  out  1  row-pointer store write strobe.
REQ-013 row_addr  out  ROW_AW  row-pointer index.
REQ-014 row_data  out  32  cumulative nonzero count.
REQ-015 nnz_count  out  NNZ_AW+1  nonzeros stored so far.
REQ-016 done  out  1  matrix fully encoded; stays high until the next start.
REQ-017 overflow  out  1  sticky; at least one nonzero was dropped.

Function
REQ-018 FSM states: IDLE, RUN, DONE. Reset state is IDLE.
REQ-019 IDLE: in_ready=0; on start -> RUN.
REQ-020 IDLE->RUN: clear row, col, nnz and overflow, and issue one row write at the next edge with row_addr=0 and row_data=0.
REQ-021 RUN: in_ready=1, except in the cycle where the row-0 write is issued.
REQ-022 Accepted element, nonzero, nnz < 2^NNZ_AW: next cycle sp_we=1, sp_addr=nnz, sp_data=in_data, col_data=col; nnz increments by 1.
REQ-023 Accepted element equal to 0: no sp write; only col advances.
REQ-024 Accepted nonzero with nnz = 2^NNZ_AW: no write, nnz holds, overflow set to 1.
REQ-025 col wraps COLS-1 -> 0; on that wrap row increments.
REQ-026 Accepted element with col=COLS-1: next cycle row_we=1, row_addr=row+1, row_data=nnz including that element, in the same cycle as any sp write for it.
REQ-027 Accepted element with col=COLS-1 and row=ROWS-1 -> DONE at the next edge; done=1 in that same cycle.
REQ-028 DONE: in_ready=0, outputs hold; start -> RUN and behaves as REQ-020.
REQ-029 start during RUN is ignored.
REQ-030 in_valid=0 in RUN: no state change and no writes.
REQ-031 All write outputs are registered: latency from transfer to strobe is exactly 1 cycle.
REQ-032 sp_we and row_we are single-cycle pulses, except during back-to-back transfers.

Reset
REQ-033 rst low, at any time including mid-matrix: asynchronously go to IDLE and clear every output to 0, with counters at 0.
REQ-034 No write strobe is asserted in the first cycle after rst rises.

Verification
REQ-035 ROWS=2, COLS=3; start; stream 5,0,7 / 0,0,0 -> sp writes (0,5,col0), (1,7,col2); row writes (0,0), (1,2), (2,2); done=1; nnz_count=2.
REQ-036 All-zero 2x3 matrix -> no sp_we; row writes (0,0), (1,0), (2,0); done=1.
REQ-037 NNZ_AW=2, 2x3 matrix of all ones -> 4 sp writes at addr 0..3; overflow=1; final row_data=4.
REQ-038 Stall: in_valid toggles every cycle -> output equals the unstalled run, with each strobe exactly 1 cycle after its transfer.
REQ-039 rst low after 4 transfers -> all outputs 0 immediately; a new start then gives a correct full encoding from row 0.
REQ-040 start in DONE -> second matrix re-encoded from sp_addr=0 and row_addr=0, with overflow cleared.

Source files
------------

// File: rtl/csr_encoder.sv
// Streams a dense row-major matrix and emits its CSR form: a value/column store
// write per nonzero and a row-pointer write per completed row, all one cycle after the transfer.
module csr_encoder #(
  parameter int ROWS   = 560,
  parameter int COLS   = 1120,
  parameter int NNZ_AW = 14,
  parameter int ROW_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sp_we,
  output logic [NNZ_AW-1:0] sp_addr,
  output logic [31:0]       sp_data,
  output logic [31:0]       col_data,
  output logic              row_we,
  output logic [ROW_AW-1:0] row_addr,
  output logic [31:0]       row_data,
  output logic [NNZ_AW:0]   nnz_count,
  output logic              done,
  output logic              overflow
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0]     COL_LAST = CW'(COLS - 1);
  localparam logic [CW-1:0]     COL_ONE  = CW'(1);
  localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(ROWS - 1);
  localparam logic [ROW_AW-1:0] ROW_ONE  = ROW_AW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [CW-1:0]     col_r;
  logic [ROW_AW-1:0] row_r;
  logic [NNZ_AW:0]   nnz_r;
  logic              overflow_r;
  logic              first_r;

  logic              launch_s;
  logic              accept_s;
  logic              nonzero_s;
  logic              store_s;
  logic              drop_s;
  logic              col_last_s;
  logic [NNZ_AW:0]   nnz_next_s;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (accept_s && col_last_s && (row_r == ROW_LAST)) state_s = DONE;
        else                                               state_s = RUN;
      end
      DONE: begin
        if (start) state_s = RUN;
        else       state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State-decoded outputs; first_r blocks input while the row-0 pointer is written
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_r)
      RUN:     in_ready = !first_r;
      DONE:    done     = 1'b1;
      default: begin
        in_ready = 1'b0;
        done     = 1'b0;
      end
    endcase
  end

  assign launch_s   = start && (state_r != RUN);
  assign accept_s   = in_valid && in_ready;
  assign nonzero_s  = (in_data != 32'd0);
  // Top bit of the count set means the store is full
  assign store_s    = accept_s && nonzero_s && !nnz_r[NNZ_AW];
  assign drop_s     = accept_s && nonzero_s && nnz_r[NNZ_AW];
  assign nnz_next_s = nnz_r + {{NNZ_AW{1'b0}}, store_s};
  assign col_last_s = (col_r == COL_LAST);

  // Counters and registered store write ports
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_r      <= '0;
      row_r      <= '0;
      nnz_r      <= '0;
      overflow_r <= 1'b0;
      first_r    <= 1'b0;
      sp_we      <= 1'b0;
      sp_addr    <= '0;
      sp_data    <= 32'd0;
      col_data   <= 32'd0;
      row_we     <= 1'b0;
      row_addr   <= '0;
      row_data   <= 32'd0;
    end else begin
      sp_we   <= 1'b0;
      row_we  <= 1'b0;
      first_r <= 1'b0;
      if (launch_s) begin
        col_r      <= '0;
        row_r      <= '0;
        nnz_r      <= '0;
        overflow_r <= 1'b0;
        first_r    <= 1'b1;
        row_we     <= 1'b1;
        row_addr   <= '0;
        row_data   <= 32'd0;
      end else if (accept_s) begin
        nnz_r <= nnz_next_s;
        if (store_s) begin
          sp_we    <= 1'b1;
          sp_addr  <= nnz_r[NNZ_AW-1:0];
          sp_data  <= in_data;
          col_data <= {{(32-CW){1'b0}}, col_r};
        end else if (drop_s) begin
          overflow_r <= 1'b1;
        end else begin
          overflow_r <= overflow_r;
        end
        if (col_last_s) begin
          col_r    <= '0;
          row_r    <= row_r + ROW_ONE;
          row_we   <= 1'b1;
          row_addr <= row_r + ROW_ONE;
          row_data <= {{(31-NNZ_AW){1'b0}}, nnz_next_s};
        end else begin
          col_r <= col_r + COL_ONE;
        end
      end else begin
        nnz_r <= nnz_r;
      end
    end
  end

  assign nnz_count = nnz_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_csr_encoder.sv
// Directed bench for csr_encoder on a 2x3 matrix with a 4-entry nonzero store.
module tb_csr_encoder;

  localparam int ROWS   = 2;
  localparam int COLS   = 3;
  localparam int NNZ_AW = 2;
  localparam int ROW_AW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       in_data = 32'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              sp_we;
  logic [NNZ_AW-1:0] sp_addr;
  logic [31:0]       sp_data;
  logic [31:0]       col_data;
  logic              row_we;
  logic [ROW_AW-1:0] row_addr;
  logic [31:0]       row_data;
  logic [NNZ_AW:0]   nnz_count;
  logic              done;
  logic              overflow;

  csr_encoder #(.ROWS(ROWS), .COLS(COLS), .NNZ_AW(NNZ_AW), .ROW_AW(ROW_AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sp_we(sp_we), .sp_addr(sp_addr), .sp_data(sp_data),
    .col_data(col_data), .row_we(row_we), .row_addr(row_addr), .row_data(row_data),
    .nnz_count(nnz_count), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int col;
    int cyc;
  } wr_t;

  typedef logic [31:0] mat_t [6];

  wr_t sp_q[$];
  wr_t row_q[$];
  int  xf_q[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;

  mat_t m_basic = '{32'd5, 32'd0, 32'd7, 32'd0, 32'd0, 32'd0};
  mat_t m_zero  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
  mat_t m_ones  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
  mat_t m_mid   = '{32'd5, 32'd0, 32'd7, 32'd3, 32'd0, 32'd0};

  // Log strobes and transfers mid-cycle, away from the active edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sp_we)  sp_q.push_back('{int'(sp_addr), int'(sp_data), int'(col_data), cyc});
    if (row_we) row_q.push_back('{int'(row_addr), int'(row_data), 0, cyc});
    if (in_valid && in_ready) xf_q.push_back(cyc);
  end

  task automatic clear_logs;
    sp_q.delete();
    row_q.delete();
    xf_q.delete();
  endtask

  task automatic start_matrix;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send(input mat_t v, input int n, input bit stall);
    int i = 0;
    int guard = 0;
    bit tog = 1'b0;
    bit fire;
    while (i < n && guard < 200) begin
      in_data  = v[i];
      in_valid = stall ? tog : 1'b1;
      tog = !tog;
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) i++;
      guard++;
    end
    in_valid = 1'b0;
    in_data  = 32'd0;
    total++;
    if (i < n) begin
      bad++;
      $display("FAIL send_timeout: sent %0d of %0d elements", i, n);
    end
  endtask

  task automatic test_reset;
    #3;
    total++;
    if ({in_ready, sp_we, sp_addr, sp_data, col_data, row_we, row_addr, row_data, nnz_count, done, overflow} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b sp_we=%b row_we=%b nnz=%0d done=%b ovf=%b, want all 0",
               in_ready, sp_we, row_we, nnz_count, done, overflow);
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({sp_we, row_we, in_ready} !== 3'b000) begin
        bad++;
        $display("FAIL reset_release: got sp_we=%b row_we=%b in_ready=%b, want 000", sp_we, row_we, in_ready);
      end
    end
  endtask

  task automatic test_sparse(input string tag, input bit stall);
    clear_logs();
    start_matrix();
    total++;
    if ({overflow, done, nnz_count} !== '0) begin
      bad++;
      $display("FAIL %s launch_clear: got ovf=%b done=%b nnz=%0d, want 0/0/0", tag, overflow, done, nnz_count);
    end
    send(m_basic, 6, stall);
    repeat (2) @(negedge clk);
    total++;
    if ({done, in_ready, overflow, nnz_count} !== {1'b1, 1'b0, 1'b0, 3'd2}) begin
      bad++;
      $display("FAIL %s final: got done=%b ready=%b ovf=%b nnz=%0d, want 1/0/0/2", tag, done, in_ready, overflow, nnz_count);
    end
    total++;
    if (sp_q.size() != 2 || row_q.size() != 3 || xf_q.size() != 6) begin
      bad++;
      $display("FAIL %s counts: got sp=%0d row=%0d xfer=%0d, want 2/3/6", tag, sp_q.size(), row_q.size(), xf_q.size());
    end else begin
      total++;
      if (sp_q[0].addr != 0 || sp_q[0].data != 5 || sp_q[0].col != 0 ||
          sp_q[1].addr != 1 || sp_q[1].data != 7 || sp_q[1].col != 2) begin
        bad++;
        $display("FAIL %s sp_writes: got (%0d,%0d,%0d) (%0d,%0d,%0d), want (0,5,0) (1,7,2)", tag,
                 sp_q[0].addr, sp_q[0].data, sp_q[0].col, sp_q[1].addr, sp_q[1].data, sp_q[1].col);
      end
      total++;
      if (row_q[0].addr != 0 || row_q[0].data != 0 || row_q[1].addr != 1 || row_q[1].data != 2 ||
          row_q[2].addr != 2 || row_q[2].data != 2) begin
        bad++;
        $display("FAIL %s row_writes: got (%0d,%0d) (%0d,%0d) (%0d,%0d), want (0,0) (1,2) (2,2)", tag,
                 row_q[0].addr, row_q[0].data, row_q[1].addr, row_q[1].data, row_q[2].addr, row_q[2].data);
      end
      total++;
      if (sp_q[0].cyc != xf_q[0] + 1 || sp_q[1].cyc != xf_q[2] + 1 ||
          row_q[1].cyc != xf_q[2] + 1 || row_q[2].cyc != xf_q[5] + 1 || xf_q[0] <= row_q[0].cyc) begin
        bad++;
        $display("FAIL %s latency: got sp at %0d,%0d rows at %0d,%0d,%0d xfers at %0d,%0d,%0d, want strobe = xfer+1 and first xfer after row0",
                 tag, sp_q[0].cyc, sp_q[1].cyc, row_q[0].cyc, row_q[1].cyc, row_q[2].cyc, xf_q[0], xf_q[2], xf_q[5]);
      end
    end
  endtask

  task automatic test_zero;
    clear_logs();
    start_matrix();
    send(m_zero, 6, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (sp_q.size() != 0 || row_q.size() != 3 || done !== 1'b1 || nnz_count !== 3'd0) begin
      bad++;
      $display("FAIL zero_counts: got sp=%0d row=%0d done=%b nnz=%0d, want 0/3/1/0", sp_q.size(), row_q.size(), done, nnz_count);
    end else begin
      total++;
      if (row_q[0].addr != 0 || row_q[0].data != 0 || row_q[1].addr != 1 || row_q[1].data != 0 ||
          row_q[2].addr != 2 || row_q[2].data != 0) begin
        bad++;
        $display("FAIL zero_rows: got (%0d,%0d) (%0d,%0d) (%0d,%0d), want (0,0) (1,0) (2,0)",
                 row_q[0].addr, row_q[0].data, row_q[1].addr, row_q[1].data, row_q[2].addr, row_q[2].data);
      end
    end
  endtask

  task automatic test_overflow;
    clear_logs();
    start_matrix();
    send(m_ones, 6, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if ({overflow, done, nnz_count} !== {1'b1, 1'b1, 3'd4}) begin
      bad++;
      $display("FAIL ovf_flags: got ovf=%b done=%b nnz=%0d, want 1/1/4", overflow, done, nnz_count);
    end
    total++;
    if (sp_q.size() != 4 || row_q.size() != 3 || xf_q.size() != 6) begin
      bad++;
      $display("FAIL ovf_counts: got sp=%0d row=%0d xfer=%0d, want 4/3/6", sp_q.size(), row_q.size(), xf_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (sp_q[k].addr != k || sp_q[k].data != 1 || sp_q[k].col != k % 3 || sp_q[k].cyc != xf_q[k] + 1) begin
          bad++;
          $display("FAIL ovf_sp%0d: got addr=%0d data=%0d col=%0d cyc=%0d, want %0d/1/%0d/%0d",
                   k, sp_q[k].addr, sp_q[k].data, sp_q[k].col, sp_q[k].cyc, k, k % 3, xf_q[k] + 1);
        end
      end
      total++;
      if (row_q[1].data != 3 || row_q[2].addr != 2 || row_q[2].data != 4) begin
        bad++;
        $display("FAIL ovf_rows: got row1 data=%0d row2=(%0d,%0d), want 3 and (2,4)", row_q[1].data, row_q[2].addr, row_q[2].data);
      end
    end
  endtask

  task automatic test_midreset;
    clear_logs();
    start_matrix();
    send(m_mid, 4, 1'b0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    total++;
    if ({nnz_count, in_ready, row_we, sp_we, done} !== {3'd3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL start_in_run: got nnz=%0d ready=%b row_we=%b sp_we=%b done=%b, want 3/1/0/0/0",
               nnz_count, in_ready, row_we, sp_we, done);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({in_ready, sp_we, sp_addr, sp_data, col_data, row_we, row_addr, row_data, nnz_count, done, overflow} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got nnz=%0d sp_addr=%0d row_addr=%0d ready=%b, want all 0",
               nnz_count, sp_addr, row_addr, in_ready);
    end
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(negedge clk);
    total++;
    if ({sp_we, row_we} !== 2'b00) begin
      bad++;
      $display("FAIL midreset_release: got sp_we=%b row_we=%b, want 00", sp_we, row_we);
    end
    test_sparse("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_sparse("basic", 1'b0);
    test_zero();
    test_overflow();
    test_sparse("restart", 1'b0);
    test_sparse("stall", 1'b1);
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
